// File: rtl/sdo_sched.sv
// Sample scheduler for the S/PDIF encoder: buffers PCM pairs and hands one pair per frame period.
// Rate changes are sequenced through a mute period and applied at an encoder block start.
module sdo_sched #(
    parameter int unsigned FRAME_DIV   = 512,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned START_LEVEL = 4,
    parameter int unsigned MUTE_FRAMES = 4,
    parameter logic [3:0]  FREQ_INIT   = 4'b0010,
    localparam int unsigned LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          dac_clk,
    input  logic          dac_rst,
    input  logic          enable,
    input  logic [23:0]   pcm_lch,
    input  logic [23:0]   pcm_rch,
    input  logic          pcm_valid,
    output logic          pcm_ready,
    input  logic [3:0]    cfg_freq,
    input  logic          cfg_wr,
    output logic          cfg_busy,
    input  logic          sdo_sync,
    output logic [23:0]   dac_lch,
    output logic [23:0]   dac_rch,
    output logic          dac_req,
    output logic [3:0]    freq_mode,
    output logic [LW-1:0] fifo_level,
    output logic          underrun,
    output logic [1:0]    state
);
    localparam int unsigned DW = $clog2(FRAME_DIV);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned MW = $clog2(MUTE_FRAMES + 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StMute  = 2'd2,
        StApply = 2'd3
    } state_e;

    state_e        r_state, w_state_d;
    logic [DW-1:0] r_div;
    logic [47:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [LW-1:0] r_level;
    logic          r_req, r_under, r_busy, w_busy_d, r_sync_q;
    logic [23:0]   r_lch, r_rch;
    logic [MW-1:0] r_mute, w_mute_d;
    logic [3:0]    r_pending, w_pending_d, r_freq, w_freq_d;
    logic          w_tick, w_ready, w_push, w_pop, w_empty, w_sync_rise;
    logic [47:0]   w_head;

    assign w_tick      = (r_div == DW'(FRAME_DIV - 2));
    assign w_empty     = (r_level == '0);
    // Ready deliberately ignores a same-cycle pop.
    assign w_ready     = enable && (r_level < LW'(FIFO_DEPTH));
    assign w_push      = pcm_valid && w_ready;
    assign w_pop       = w_tick && (r_state == StRun) && !w_empty;
    assign w_head      = r_mem[r_rptr];
    assign w_sync_rise = sdo_sync && !r_sync_q;

    always_ff @(posedge dac_clk or posedge dac_rst) begin
        if (dac_rst) begin
            r_div <= '0;
        end else if (r_div == DW'(FRAME_DIV - 1)) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DW'(1);
        end
    end

    always_ff @(posedge dac_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {pcm_lch, pcm_rch};
        end
    end

    always_ff @(posedge dac_clk or posedge dac_rst) begin
        if (dac_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (!enable) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            if (w_push && !w_pop) begin
                r_level <= r_level + LW'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LW'(1);
            end
        end
    end

    always_ff @(posedge dac_clk or posedge dac_rst) begin
        if (dac_rst) begin
            r_req   <= 1'b0;
            r_under <= 1'b0;
            r_lch   <= '0;
            r_rch   <= '0;
        end else begin
            r_req   <= w_tick;
            r_under <= w_tick && (r_state == StRun) && w_empty;
            if (w_tick) begin
                r_lch <= w_pop ? w_head[47:24] : '0;
                r_rch <= w_pop ? w_head[23:0]  : '0;
            end
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_mute_d    = r_mute;
        w_pending_d = r_pending;
        w_busy_d    = r_busy;
        w_freq_d    = r_freq;
        case (r_state)
            StIdle: begin
                if (enable && (r_level >= LW'(START_LEVEL))) w_state_d = StRun;
            end
            StRun: begin
                if (w_tick && w_empty) w_state_d = StIdle;
            end
            StMute: begin
                if (w_tick) begin
                    w_mute_d = r_mute + MW'(1);
                    if (r_mute == MW'(MUTE_FRAMES - 1)) w_state_d = StApply;
                end
            end
            StApply: begin
                if (w_sync_rise) begin
                    w_freq_d  = r_pending;
                    w_busy_d  = 1'b0;
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
        // A rate change in flight runs to completion even with enable low.
        if (!enable && (r_state == StIdle || r_state == StRun)) w_state_d = StIdle;
        if (cfg_wr && !r_busy) begin
            w_pending_d = cfg_freq;
            w_busy_d    = 1'b1;
            w_mute_d    = '0;
            w_state_d   = StMute;
        end
    end

    always_ff @(posedge dac_clk or posedge dac_rst) begin
        if (dac_rst) begin
            r_state   <= StIdle;
            r_mute    <= '0;
            r_pending <= '0;
            r_busy    <= 1'b0;
            r_freq    <= FREQ_INIT;
            r_sync_q  <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_mute    <= w_mute_d;
            r_pending <= w_pending_d;
            r_busy    <= w_busy_d;
            r_freq    <= w_freq_d;
            r_sync_q  <= sdo_sync;
        end
    end

    assign pcm_ready  = w_ready;
    assign cfg_busy   = r_busy;
    assign dac_lch    = r_lch;
    assign dac_rch    = r_rch;
    assign dac_req    = r_req;
    assign freq_mode  = r_freq;
    assign fifo_level = r_level;
    assign underrun   = r_under;
    assign state      = r_state;
endmodule

// File: tb/tb_sdo_sched.sv
// Bench for sdo_sched: directed scenarios with random data, checked every cycle against a
// queue-based model of the scheduler rules.
module tb_sdo_sched;
    localparam int FD = 512, DEPTH = 8, START = 4, MF = 4;

    logic        dac_clk = 1'b0, dac_rst = 1'b0, enable = 1'b0, pcm_valid = 1'b0;
    logic        cfg_wr = 1'b0, sdo_sync = 1'b0;
    logic [23:0] pcm_lch = '0, pcm_rch = '0;
    logic [3:0]  cfg_freq = '0;
    logic        pcm_ready, cfg_busy, dac_req, underrun;
    logic [23:0] dac_lch, dac_rch;
    logic [3:0]  freq_mode, fifo_level;
    logic [1:0]  state;

    sdo_sched dut (
        .dac_clk(dac_clk), .dac_rst(dac_rst), .enable(enable), .pcm_lch(pcm_lch),
        .pcm_rch(pcm_rch), .pcm_valid(pcm_valid), .pcm_ready(pcm_ready), .cfg_freq(cfg_freq),
        .cfg_wr(cfg_wr), .cfg_busy(cfg_busy), .sdo_sync(sdo_sync), .dac_lch(dac_lch),
        .dac_rch(dac_rch), .dac_req(dac_req), .freq_mode(freq_mode), .fifo_level(fifo_level),
        .underrun(underrun), .state(state)
    );

    always #5 dac_clk = ~dac_clk;

    int n_checks = 0, n_err = 0, req_cnt = 0, cyc_no = 0, sync_cnt = 500;

    // Reference model: FIFO as a queue, state as the numeric code of the state output.
    logic [47:0] m_q[$];
    int          m_div, m_state, m_mute;
    logic [3:0]  m_pending, m_freq;
    bit          m_busy, m_sync_q, m_req, m_under;
    logic [23:0] m_l, m_r;

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_div = 0; m_state = 0; m_mute = 0; m_pending = '0; m_busy = 0;
        m_freq = 4'b0010; m_sync_q = 0; m_req = 0; m_under = 0; m_l = '0; m_r = '0;
    endtask

    task automatic model_step();
        int lvl = m_q.size();
        bit tick = (m_div == FD - 2);
        bit push = pcm_valid && enable && (lvl < DEPTH);
        bit pop = tick && (m_state == 1) && (lvl > 0);
        bit busy_pre = m_busy;
        int ns = m_state;
        m_under = tick && (m_state == 1) && (lvl == 0);
        m_req = tick;
        if (tick) begin
            if (pop) {m_l, m_r} = m_q[0];
            else {m_l, m_r} = 48'h0;
        end
        if (!enable) m_q.delete();
        else begin
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back({pcm_lch, pcm_rch});
        end
        case (m_state)
            0: if (enable && lvl >= START) ns = 1;
            1: if (tick && lvl == 0) ns = 0;
            2: if (tick) begin
                m_mute++;
                if (m_mute == MF) ns = 3;
            end
            default: if (sdo_sync && !m_sync_q) begin
                m_freq = m_pending; m_busy = 0; ns = 0;
            end
        endcase
        if (!enable && (m_state == 0 || m_state == 1)) ns = 0;
        if (cfg_wr && !busy_pre) begin
            m_pending = cfg_freq; m_busy = 1; m_mute = 0; ns = 2;
        end
        m_sync_q = sdo_sync;
        m_div = (m_div + 1) % FD;
        m_state = ns;
    endtask

    task automatic check_outputs();
        chk("state", 48'(state), 48'(m_state));
        chk("freq_mode", 48'(freq_mode), 48'(m_freq));
        chk("cfg_busy", 48'(cfg_busy), 48'(m_busy));
        chk("dac_req", 48'(dac_req), 48'(m_req));
        chk("dac_data", {dac_lch, dac_rch}, {m_l, m_r});
        chk("underrun", 48'(underrun), 48'(m_under));
        chk("fifo_level", 48'(fifo_level), 48'(m_q.size()));
    endtask

    // One clock: drive sync, check combinational ready, step model at the edge, check outputs.
    task automatic cyc();
        if (sync_cnt == 0) sync_cnt = $urandom_range(300, 900);
        else sync_cnt--;
        sdo_sync = (sync_cnt < 4);
        #1;
        chk("pcm_ready", 48'(pcm_ready), 48'(enable && (m_q.size() < DEPTH)));
        @(posedge dac_clk);
        if (!dac_rst) model_step();
        #1;
        cyc_no++;
        if (dac_req) req_cnt++;
        check_outputs();
    endtask

    task automatic do_reset();
        dac_rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        repeat (3) cyc();
        dac_rst = 1'b0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!dac_req && n < FD + 8) begin cyc(); n++; end
        chk("req_seen", 48'(dac_req), 48'h1);
    endtask

    task automatic rand_cycles(input int n, input int permille);
        for (int i = 0; i < n; i++) begin
            pcm_valid = ($urandom_range(999) < permille);
            pcm_lch = 24'($urandom);
            pcm_rch = 24'($urandom);
            cyc();
        end
    endtask

    initial begin
        int n, nreq, t_prev;
        do_reset();
        chk("rst_freq", 48'(freq_mode), 48'h2);

        // Basic run: four pairs then underrun.
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pcm_valid = 1'b1; pcm_lch = 24'h000100 + 24'(i); pcm_rch = 24'h800000 + 24'(i);
            cyc();
        end
        pcm_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wait_req();
            if (k < 4) begin
                chk("basic_l", 48'(dac_lch), 48'(24'h000100 + 24'(k)));
                chk("basic_r", 48'(dac_rch), 48'(24'h800000 + 24'(k)));
            end else begin
                chk("basic_zero", {dac_lch, dac_rch}, 48'h0);
                chk("basic_underrun", 48'(underrun), 48'h1);
                chk("basic_idle", 48'(state), 48'h0);
            end
            cyc();
        end

        // Full FIFO, then a pop coinciding with a refused push.
        pcm_valid = 1'b1;
        n = 0;
        while (fifo_level != 4'd8 && n < 20) begin
            pcm_lch = 24'($urandom); pcm_rch = 24'($urandom); cyc(); n++;
        end
        chk("full_level", 48'(fifo_level), 48'd8);
        chk("full_ready", 48'(pcm_ready), 48'h0);
        n = 0;
        while (m_div != FD - 2 && n < FD + 8) begin cyc(); n++; end
        cyc();
        chk("pop_refused_level", 48'(fifo_level), 48'd7);
        chk("pop_ready_back", 48'(pcm_ready), 48'h1);

        // Random streaming, busy then sparse so underruns occur.
        rand_cycles(2000, 500);
        rand_cycles(6000, 1);

        // Rate change from RUN, with an ignored second request during MUTE.
        pcm_valid = 1'b1;
        n = 0;
        while ((m_state != 1 || m_div >= FD - 20 || m_div < 2) && n < 3 * FD) begin
            cyc(); n++;
        end
        chk("rc_in_run", 48'(state), 48'h1);
        cfg_freq = 4'b0000; cfg_wr = 1'b1; cyc(); cfg_wr = 1'b0;
        nreq = req_cnt;
        chk("rc_busy", 48'(cfg_busy), 48'h1);
        chk("rc_mute", 48'(state), 48'h2);
        rand_cycles(10, 700);
        cfg_freq = 4'b1100; cfg_wr = 1'b1; cyc(); cfg_wr = 1'b0;
        chk("rc_second_ignored", 48'(state), 48'h2);
        n = 0;
        while (state != 2'd3 && n < (MF + 1) * FD + 10) begin cyc(); n++; end
        chk("rc_apply", 48'(state), 48'h3);
        chk("rc_mute_frames", 48'(req_cnt - nreq), 48'(MF));
        n = 0;
        while (cfg_busy && n < 3000) begin cyc(); n++; end
        chk("rc_done", 48'(cfg_busy), 48'h0);
        chk("rc_freq", 48'(freq_mode), 48'h0);
        rand_cycles(2 * FD, 300);

        // Disable with five entries buffered.
        enable = 1'b0; pcm_valid = 1'b0; cyc();
        enable = 1'b1;
        n = 0;
        while (m_div != 0 && n < FD + 8) begin cyc(); n++; end
        for (int i = 0; i < 5; i++) begin
            pcm_valid = 1'b1; pcm_lch = 24'($urandom); pcm_rch = 24'($urandom); cyc();
        end
        pcm_valid = 1'b0;
        chk("dis_level5", 48'(fifo_level), 48'd5);
        enable = 1'b0; cyc();
        chk("dis_level0", 48'(fifo_level), 48'h0);
        chk("dis_ready", 48'(pcm_ready), 48'h0);
        t_prev = -1; nreq = 0;
        for (int i = 0; i < 2 * FD; i++) begin
            cyc();
            if (dac_req) begin
                nreq++;
                chk("dis_zero", {dac_lch, dac_rch}, 48'h0);
                if (t_prev >= 0) chk("dis_period", 48'(cyc_no - t_prev), 48'(FD));
                t_prev = cyc_no;
            end
        end
        chk("dis_reqs", 48'(nreq), 48'd2);

        // Reset while waiting in APPLY.
        enable = 1'b1; cfg_freq = 4'b0101; cfg_wr = 1'b1; cyc(); cfg_wr = 1'b0;
        n = 0;
        while (state != 2'd3 && n < (MF + 1) * FD + 10) begin cyc(); n++; end
        chk("ra_apply", 48'(state), 48'h3);
        dac_rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        chk("ra_freq", 48'(freq_mode), 48'h2);
        chk("ra_idle", 48'(state), 48'h0);
        repeat (3) cyc();
        dac_rst = 1'b0;
        rand_cycles(200, 500);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/sdo_sched.md
# sdo_sched

Sample scheduler and configuration sequencer for the S/PDIF encoder. It buffers stereo PCM from an upstream producer in a FIFO and issues one `dac_req` strobe with a held sample pair per frame period of `dac_clk` (48 kHz × 512). It handles start-up fill and underrun by sending silence. It changes `freq_mode` only after a mute period, and only at an S/PDIF block boundary, so no channel-status block carries mixed rate bits.

## Interface
- `FRAME_DIV`, 512: `dac_clk` cycles per stereo frame (≥4).
- `FIFO_DEPTH`, 8: stereo entries; power of 2, ≥2.
- `START_LEVEL`, 4: FIFO level required to leave IDLE; 1..`FIFO_DEPTH`.
- `MUTE_FRAMES`, 4: silent frames sent before a rate change; ≥1.
- `FREQ_INIT`, 4'b0010: reset value of `freq_mode` (48 kHz; bit0 is sent first, at channel-status bit 24).
- `LW` = clog2(`FIFO_DEPTH`)+1 (derived).

Ports:
- `dac_clk`  in  1  clock.
- `dac_rst`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  run enable; low flushes the FIFO.
- `pcm_lch`  in  24  left sample.
- `pcm_rch`  in  24  right sample.
- `pcm_valid`  in  1  producer has a sample pair.
- `pcm_ready`  out  1  FIFO accepts this cycle.
- `cfg_freq`  in  4  requested `freq_mode`.
- `cfg_wr`  in  1  one-cycle request strobe.
- `cfg_busy`  out  1  a rate change is in progress.
- `sdo_sync`  in  1  encoder frame-sync level; its rising edge marks block start.
- `dac_lch`  out  24  left sample to the encoder.
- `dac_rch`  out  24  right sample to the encoder.
- `dac_req`  out  1  one-cycle load strobe.
- `freq_mode`  out  4  rate code to the encoder.
- `fifo_level`  out  LW  current FIFO occupancy.
- `underrun`  out  1  one-cycle pulse.
- `state`  out  2  IDLE=0, RUN=1, MUTE=2, APPLY=3.

## Operation
- **Divider.** Counter `div` runs 0..`FRAME_DIV`-1 and wraps. It always runs, in every state and regardless of `enable`. `tick` = (`div`==`FRAME_DIV`-2).
- **FIFO handshake.**
  - `pcm_ready` = `enable` & (level < `FIFO_DEPTH`), combinational.
  - A push happens when `pcm_valid` & `pcm_ready`.
  - A pop happens only on a `tick` in RUN when the FIFO is non-empty.
  - Push and pop in the same cycle leave the level unchanged. A full FIFO with a same-cycle pop still refuses the push, because `pcm_ready` ignores the pop.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
- **Output.** On every `tick` edge, `dac_req`←1 and {`dac_lch`,`dac_rch`} are loaded:
  - with the FIFO head if in RUN and the FIFO is non-empty;
  - with 0 otherwise.
  - `dac_req`←0 on the next edge. Data holds until the next `tick`.
- **Enable.** `enable`=0 clears both pointers and the level to 0 every cycle. The state goes to IDLE, unless the state is MUTE or APPLY; those finish their sequence.
- **FSM.**
  - **IDLE.** Sends zeros. Goes to RUN when `enable` & level ≥ `START_LEVEL`.
  - **RUN.** At a `tick` with the FIFO empty: load zeros, pulse `underrun` in the same cycle, go to IDLE.
  - **MUTE.** Sends zeros and does not pop; pushes are still accepted. A frame counter increments on each `tick`. After `MUTE_FRAMES` ticks, go to APPLY.
  - **APPLY.** Sends zeros. On a `sdo_sync` rising edge (detected with a registered copy, reset 0): `freq_mode`←pending, `cfg_busy`←0, go to IDLE.
  - A `cfg_wr` with `cfg_busy`=0 in any state: latch `cfg_freq` into pending, `cfg_busy`←1, go to MUTE, and clear the mute counter.
  - A `cfg_wr` while `cfg_busy`=1 is ignored.
  - `cfg_wr` takes priority over the RUN→IDLE underrun transition in the same cycle; `underrun` still pulses.

## Timing
- **Reset values:**
  - 0: `dac_lch`, `dac_rch`, `dac_req`, `cfg_busy`, `underrun`, `fifo_level`, `div`, pointers, mute counter, `sdo_sync` delay register.
  - `freq_mode`=`FREQ_INIT`; `state`=IDLE.
  - `pcm_ready` follows `enable`.
- **Request timing.** `dac_req` is high exactly while `div`==`FRAME_DIV`-1, once per `FRAME_DIV` cycles. It is never suppressed.
- **Latency.** A push at cycle t is visible in `fifo_level` at t+1. It is eligible to be popped at the first `tick` at or after t+1.
- **RUN entry.** The IDLE→RUN transition happens 1 cycle after the level condition is met. The first pop is at the next `tick`.
- **Rate-change bound.** From `cfg_wr` to the `freq_mode` change is at most (`MUTE_FRAMES`+1)·`FRAME_DIV` + one block period + 2 cycles.
- **Reset mid-operation.** Reset clears the FIFO and aborts any rate change; the pending value is discarded.

## Test plan
- **Basic run.** Reset, `enable`=1, push 4 pairs L=0x000100+i, R=0x800000+i → IDLE→RUN. `dac_req` pulses every 512 cycles with pairs i=0..3 in order. The next `tick` gives zeros with `underrun`=1 for 1 cycle, and `state`=IDLE.
- **Full FIFO.** Hold `pcm_valid` with no pops → 8 pushes accepted, `pcm_ready`=0, `fifo_level`=8. A `tick` pop and a push in the same cycle → push refused, level 7, `pcm_ready`=1 on the next cycle.
- **Rate change.** `cfg_freq`=4'b0000 + `cfg_wr` while in RUN → `cfg_busy`=1. Exactly 4 zero frames (`state`=MUTE), then APPLY. `freq_mode` becomes 0 on the cycle after a `sdo_sync` rise, then `cfg_busy`=0 and buffered data resumes.
- **Busy request ignored.** A second `cfg_wr` (4'b1100) during MUTE → ignored; the final `freq_mode`=4'b0000.
- **Disable.** Drop `enable` with 5 entries buffered → level 0 the next cycle, `pcm_ready`=0, zeros sent. `dac_req` keeps its 512-cycle period.
- **Reset during APPLY.** Assert `dac_rst` in APPLY → all outputs take their reset values, `freq_mode`=4'b0010, `state`=IDLE.
